mmcm_reconfig_sequencer: RTL

//  Upstream controller for mmcme2_drp_top.

---
 rtl/mmcm_reconfig_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmcm_reconfig_sequencer.sv
// Sequences clock-profile changes for the MMCM DRP top: queues one host request, pulses SSTEP,
// waits for SRDY and a stable LOCKED, retries on timeout and reports DONE/ERR plus the active profile.
module mmcm_reconfig_sequencer #(
    parameter int STATE_W      = 8,
    parameter int NUM_STATES   = 5,
    parameter int SRDY_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 64,
    parameter int MAX_RETRY    = 2
) (
    input  logic               CLKIN,
    input  logic               RST,
    input  logic               REQ_VALID,
    input  logic [STATE_W-1:0] REQ_STATE,
    output logic               REQ_READY,
    output logic               SSTEP,
    output logic [STATE_W-1:0] STATE,
    input  logic               SRDY,
    input  logic               LOCKED_IN,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [1:0]         ERR_CODE,
    output logic [STATE_W-1:0] CUR_STATE,
    output logic               CUR_VALID
);

    localparam int SRDY_W  = $clog2(SRDY_TIMEOUT + 1);
    localparam int LOCK_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int STAB_W  = $clog2(LOCK_STABLE + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [SRDY_W-1:0]  SRDY_LAST   = SRDY_W'(SRDY_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LIMIT  = LOCK_W'(LOCK_TIMEOUT);
    localparam logic [STAB_W-1:0]  STAB_LIMIT  = STAB_W'(LOCK_STABLE);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [STATE_W:0]   IDX_LIMIT   = (STATE_W + 1)'(NUM_STATES);

    localparam logic [1:0] ERR_LOCK_LOST = 2'd0;
    localparam logic [1:0] ERR_SRDY_TO   = 2'd1;
    localparam logic [1:0] ERR_LOCK_TO   = 2'd2;
    localparam logic [1:0] ERR_BAD_IDX   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_SRDY = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_FINISH    = 3'd5
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic               pend_valid_q, pend_valid_d;
    logic [STATE_W-1:0] pend_idx_q, pend_idx_d;
    logic [STATE_W-1:0] idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [SRDY_W-1:0]  srdy_cnt_q, srdy_cnt_d;
    logic [LOCK_W-1:0]  tot_cnt_q, tot_cnt_d;
    logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic               sstep_q, sstep_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [STATE_W-1:0] cur_state_q, cur_state_d;
    logic               cur_valid_q, cur_valid_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               lock_meta_q, lock_sync_q;

    logic               accept_s;
    logic               go_issue_s;
    logic               timeout_s;
    logic [1:0]         to_code_s;
    logic [LOCK_W-1:0]  tot_next_s;
    logic [STAB_W-1:0]  stab_next_s;

    // Next-state, counter and output computation for the sequencer FSM and pending slot.
    always_comb begin
        fsm_d        = fsm_q;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        srdy_cnt_d   = srdy_cnt_q;
        tot_cnt_d    = tot_cnt_q;
        stab_cnt_d   = stab_cnt_q;
        sstep_d      = 1'b0;
        state_d      = state_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        cur_state_d  = cur_state_q;
        cur_valid_d  = cur_valid_q;
        go_issue_s   = 1'b0;
        timeout_s    = 1'b0;
        to_code_s    = ERR_SRDY_TO;
        tot_next_s   = tot_cnt_q + LOCK_W'(1);
        stab_next_s  = lock_sync_q ? (stab_cnt_q + STAB_W'(1)) : {STAB_W{1'b0}};

        accept_s = REQ_VALID & ready_q;
        if (accept_s) begin
            pend_valid_d = 1'b1;
            pend_idx_d   = REQ_STATE;
        end else begin
            pend_idx_d   = pend_idx_q;
        end

        case (fsm_q)
            S_IDLE: begin
                if (cur_valid_q && !lock_sync_q) begin
                    cur_valid_d = 1'b0;
                    err_d       = 1'b1;
                    err_code_d  = ERR_LOCK_LOST;
                end else begin
                    err_d       = 1'b0;
                end
                if (pend_valid_q) begin
                    fsm_d        = S_CHECK;
                    idx_d        = pend_idx_q;
                    pend_valid_d = 1'b0;
                end else begin
                    fsm_d        = S_IDLE;
                end
            end
            S_CHECK: begin
                if ({1'b0, idx_q} >= IDX_LIMIT) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_IDX;
                    fsm_d      = S_IDLE;
                end else if (cur_valid_q && (idx_q == cur_state_q)) begin
                    done_d = 1'b1;
                    fsm_d  = S_IDLE;
                end else begin
                    retry_d    = {RETRY_W{1'b0}};
                    go_issue_s = 1'b1;
                end
            end
            S_ISSUE: begin
                srdy_cnt_d = {SRDY_W{1'b0}};
                fsm_d      = S_WAIT_SRDY;
            end
            S_WAIT_SRDY: begin
                // A completion seen on the final allowed cycle still counts as success.
                if (SRDY) begin
                    tot_cnt_d  = {LOCK_W{1'b0}};
                    stab_cnt_d = {STAB_W{1'b0}};
                    fsm_d      = S_WAIT_LOCK;
                end else if (srdy_cnt_q == SRDY_LAST) begin
                    timeout_s = 1'b1;
                    to_code_s = ERR_SRDY_TO;
                end else begin
                    srdy_cnt_d = srdy_cnt_q + SRDY_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (tot_next_s == LOCK_LIMIT) begin
                    timeout_s = 1'b1;
                    to_code_s = ERR_LOCK_TO;
                end else if (stab_next_s == STAB_LIMIT) begin
                    // Result becomes visible for the single FINISH cycle.
                    fsm_d       = S_FINISH;
                    cur_state_d = state_q;
                    cur_valid_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    tot_cnt_d  = tot_next_s;
                    stab_cnt_d = stab_next_s;
                end
            end
            S_FINISH: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        if (timeout_s) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d    = retry_q + RETRY_W'(1);
                go_issue_s = 1'b1;
            end else begin
                err_d      = 1'b1;
                err_code_d = to_code_s;
                fsm_d      = S_IDLE;
            end
        end else begin
            retry_d = retry_d;
        end

        if (go_issue_s) begin
            fsm_d       = S_ISSUE;
            sstep_d     = 1'b1;
            state_d     = idx_q;
            cur_valid_d = 1'b0;
        end else begin
            sstep_d = sstep_d;
        end

        ready_d = ~pend_valid_d;
        busy_d  = (fsm_d != S_IDLE) | pend_valid_d;
    end

    // State, counters, registered outputs and the LOCKED synchroniser.
    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            fsm_q        <= S_IDLE;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= {STATE_W{1'b0}};
            idx_q        <= {STATE_W{1'b0}};
            retry_q      <= {RETRY_W{1'b0}};
            srdy_cnt_q   <= {SRDY_W{1'b0}};
            tot_cnt_q    <= {LOCK_W{1'b0}};
            stab_cnt_q   <= {STAB_W{1'b0}};
            sstep_q      <= 1'b0;
            state_q      <= {STATE_W{1'b0}};
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            cur_state_q  <= {STATE_W{1'b0}};
            cur_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            srdy_cnt_q   <= srdy_cnt_d;
            tot_cnt_q    <= tot_cnt_d;
            stab_cnt_q   <= stab_cnt_d;
            sstep_q      <= sstep_d;
            state_q      <= state_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            cur_state_q  <= cur_state_d;
            cur_valid_q  <= cur_valid_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            lock_meta_q  <= LOCKED_IN;
            lock_sync_q  <= lock_meta_q;
        end
    end

    assign REQ_READY = ready_q;
    assign SSTEP     = sstep_q;
    assign STATE     = state_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign ERR_CODE  = err_code_q;
    assign CUR_STATE = cur_state_q;
    assign CUR_VALID = cur_valid_q;

endmodule
